// File: rtl/truth_table_sweeper.sv
// Walks every input combination of an N-input Boolean function and captures its truth table.
// The captured table is exposed as "tbl" because "table" is a reserved word in SystemVerilog.
module truth_table_sweeper #(
  parameter int N     = 4,
  parameter int DWELL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               gray,
  input  logic               f_in,
  output logic [N-1:0]       vars,
  output logic [N-1:0]       vars_n,
  output logic               busy,
  output logic               done,
  output logic [(1<<N)-1:0]  tbl,
  output logic [N:0]         ones
);

  // state  | meaning
  // IDLE   | waiting for start, vars parked at 0, results held
  // SETTLE | driving one combination for DWELL cycles, sampling f_in on the last
  // DONE   | one-cycle completion pulse, results valid
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned   SIZE         = 1 << N;
  localparam logic [N:0]    LAST_IDX     = (N+1)'(SIZE - 1);
  localparam logic [N:0]    IDX_ONE      = (N+1)'(1);
  localparam logic [7:0]    DWELL_RELOAD = 8'(DWELL - 1);

  state_t       state;
  state_t       state_nxt;
  logic [N:0]   index;
  logic [7:0]   dwell_cnt;
  logic         gray_q;
  logic [N-1:0] code;
  logic         last_dwell;
  logic         last_code;

  // index is one bit wider than a code so the terminal compare never sees a wrap
  assign code       = gray_q ? (index[N-1:0] ^ (index[N-1:0] >> 1)) : index[N-1:0];
  assign last_dwell = (dwell_cnt == 8'd0);
  assign last_code  = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (last_dwell && last_code) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    vars = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SETTLE: begin
        vars = code;
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        vars = '0;
      end
    endcase
  end

  assign vars_n = ~vars;

  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      dwell_cnt <= '0;
      gray_q    <= 1'b0;
      tbl       <= '0;
      ones      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gray_q    <= gray;
            tbl       <= '0;
            ones      <= '0;
            index     <= '0;
            dwell_cnt <= DWELL_RELOAD;
          end
        end
        SETTLE: begin
          if (!last_dwell) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else begin
            // ones is N+1 bits, so a full table of 2^N ones still fits
            tbl[code] <= f_in;
            ones      <= ones + {{N{1'b0}}, f_in};
            if (!last_code) begin
              index     <= index + IDX_ONE;
              dwell_cnt <= DWELL_RELOAD;
            end
          end
        end
        default: begin
          dwell_cnt <= dwell_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (DWELL=1 and DWELL=3), N=4.
// Table-driven sweeps plus hand-written reset-abort and ignored-start sequences.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start_v;
  logic [1:0]  gray_v;
  int          fsel;
  int          dsel;

  logic [3:0]  vars1, vars_n1, vars3, vars_n3;
  logic        busy1, done1, busy3, done3;
  logic [15:0] tbl1, tbl3;
  logic [4:0]  ones1, ones3;
  logic        f_in1, f_in3;

  logic [3:0]  o_vars, o_vars_n;
  logic        o_busy, o_done;
  logic [15:0] o_tbl;
  logic [4:0]  o_ones;

  int n_vec = 0;
  int n_err = 0;

  // functions under test: 0 v3, 1 v0, 2 v3&v2 | v1&~v0, 3 const 1, other const 0
  function automatic logic fn(input int sel, input logic [3:0] v);
    case (sel)
      0:       return v[3];
      1:       return v[0];
      2:       return (v[3] & v[2]) | (v[1] & ~v[0]);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb f_in1 = fn(fsel, vars1);
  always_comb f_in3 = fn(fsel, vars3);

  always_comb begin
    o_vars   = dsel != 0 ? vars3   : vars1;
    o_vars_n = dsel != 0 ? vars_n3 : vars_n1;
    o_busy   = dsel != 0 ? busy3   : busy1;
    o_done   = dsel != 0 ? done3   : done1;
    o_tbl    = dsel != 0 ? tbl3    : tbl1;
    o_ones   = dsel != 0 ? ones3   : ones1;
  end

  truth_table_sweeper #(.N(4), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .gray(gray_v[0]), .f_in(f_in1),
    .vars(vars1), .vars_n(vars_n1), .busy(busy1), .done(done1),
    .tbl(tbl1), .ones(ones1)
  );

  truth_table_sweeper #(.N(4), .DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .gray(gray_v[1]), .f_in(f_in3),
    .vars(vars3), .vars_n(vars_n3), .busy(busy3), .done(done3),
    .tbl(tbl3), .ones(ones3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sweep on instance d; noise adds stray starts at cycles 3, 10 and in DONE,
  // and flips gray at cycle 5.
  task automatic run_sweep(input int d, input logic g, input int fs,
                           input logic [15:0] exp_tbl, input int exp_ones,
                           input bit noise, input string tag);
    int dw, total, lat, ndone, first_done, seq_err, idx, code;
    logic [15:0] tbl_at_done;
    logic [4:0]  ones_at_done;
    logic [3:0]  ev;
    logic        eb, ed;
    dw = (d != 0) ? 3 : 1;
    total = 16 * dw + 6;
    lat = 16 * dw + 1;
    ndone = 0;
    first_done = 0;
    seq_err = 0;
    tbl_at_done = '0;
    ones_at_done = '0;
    dsel = d;
    fsel = fs;
    @(negedge clk);
    start_v[d] = 1'b1;
    gray_v[d]  = g;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c <= 16 * dw) begin
        idx  = (c - 1) / dw;
        code = g ? (idx ^ (idx >> 1)) : idx;
        ev = 4'(code);
        eb = 1'b1;
        ed = 1'b0;
      end else begin
        ev = 4'd0;
        eb = 1'b0;
        ed = (c == lat);
      end
      if (o_vars !== ev || o_vars_n !== ~ev || o_busy !== eb || o_done !== ed)
        seq_err++;
      if (o_done === 1'b1) begin
        ndone++;
        if (first_done == 0) begin
          first_done   = c;
          tbl_at_done  = o_tbl;
          ones_at_done = o_ones;
        end
      end
      start_v[d] = noise && (c == 3 || c == 10 || c == lat);
      if (noise && c == 5) gray_v[d] = ~gray_v[d];
    end
    start_v[d] = 1'b0;
    chk({tag, " cycle_seq_errs"}, seq_err, 0);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_cycle"}, first_done, lat);
    chk({tag, " tbl_at_done"}, tbl_at_done, exp_tbl);
    chk({tag, " ones_at_done"}, ones_at_done, exp_ones);
    chk({tag, " tbl_held"}, o_tbl, exp_tbl);
    chk({tag, " ones_held"}, o_ones, exp_ones);
  endtask

  typedef struct {
    int          d;
    logic        g;
    int          fs;
    logic [15:0] tbl;
    int          ones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ndone;
    vecs[0] = '{0, 1'b0, 0, 16'hFF00, 8};
    vecs[1] = '{0, 1'b1, 1, 16'hAAAA, 8};
    vecs[2] = '{1, 1'b0, 2, 16'hF444, 7};
    vecs[3] = '{0, 1'b0, 4, 16'h0000, 0};
    vecs[4] = '{1, 1'b1, 0, 16'hFF00, 8};
    vecs[5] = '{0, 1'b1, 2, 16'hF444, 7};
    vecs[6] = '{0, 1'b0, 3, 16'hFFFF, 16};

    rst = 1'b1;
    start_v = 2'b00;
    gray_v = 2'b00;
    fsel = 0;
    dsel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      dsel = d;
      #1;
      chk($sformatf("reset%0d vars", d), o_vars, 4'h0);
      chk($sformatf("reset%0d vars_n", d), o_vars_n, 4'hF);
      chk($sformatf("reset%0d busy", d), o_busy, 1'b0);
      chk($sformatf("reset%0d done", d), o_done, 1'b0);
      chk($sformatf("reset%0d tbl", d), o_tbl, 16'h0000);
      chk($sformatf("reset%0d ones", d), o_ones, 5'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_sweep(vecs[i].d, vecs[i].g, vecs[i].fs, vecs[i].tbl, vecs[i].ones,
                1'b0, $sformatf("vec%0d", i));

    // reset lands on the edge closing cycle 7 of a DWELL=1 sweep
    dsel = 0;
    fsel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    gray_v[0] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (c == 7) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort busy", o_busy, 1'b0);
    chk("abort done", o_done, 1'b0);
    chk("abort vars", o_vars, 4'h0);
    chk("abort vars_n", o_vars_n, 4'hF);
    chk("abort tbl", o_tbl, 16'h0000);
    chk("abort ones", o_ones, 5'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_busy === 1'b1) ndone++;
    end
    chk("abort no_done_after", ndone, 0);
    run_sweep(0, 1'b0, 0, 16'hFF00, 8, 1'b0, "after_abort");

    run_sweep(1, 1'b0, 2, 16'hF444, 7, 1'b1, "ignore_d3");
    run_sweep(0, 1'b1, 1, 16'hAAAA, 8, 1'b1, "ignore_d1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N, default 4, number of Boolean inputs driven to the function under test; legal range 1..8.
REQ-002 Parameter DWELL, default 2, cycles each input combination is held before sampling; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  sweep request, sampled on rising edge.
REQ-006 gray  input  1  order select: 0 = binary count order, 1 = Gray-code order; latched when a sweep is accepted.
REQ-007 f_in  input  1  output of the function under test, sampled once per combination.
REQ-008 vars  output  N  true input literals driven to the function under test.
REQ-009 vars_n  output  N  complemented literals; equal to ~vars in every cycle.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 table  output  2^N  captured truth table; bit i = f_in sampled while vars == i.
REQ-013 ones  output  N+1  count of 1 bits captured in table during the last sweep.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE and DONE; no other reachable state.
REQ-015 IDLE: vars = 0, busy = 0, done = 0; table and ones hold the previous values.
REQ-016 IDLE with start = 1 SHALL do the following in the next state: latch gray; clear table and ones; set index = 0 and dwell counter = DWELL-1; enter SETTLE.
REQ-017 SETTLE: busy = 1; vars = index when the latched gray = 0, else index ^ (index >> 1).
REQ-018 SETTLE with dwell counter != 0 SHALL decrement the counter and hold vars.
REQ-019 SETTLE with dwell counter = 0 SHALL write f_in into table[vars] and add f_in to ones on the same edge.
REQ-020 On that edge, if index = 2^N-1, go to DONE; else increment index, reload counter to DWELL-1 and stay in SETTLE.
REQ-021 Each combination SHALL be driven for exactly DWELL consecutive cycles; f_in SHALL be sampled at the end of the last of those cycles.
REQ-022 DONE SHALL last one cycle with done = 1, busy = 0 and vars = 0, then return to IDLE.
REQ-023 table and ones SHALL be valid from the DONE cycle and SHALL be held until the next accepted start.
REQ-024 Latency: with start accepted at edge 0, done SHALL be high in cycle 2^N*DWELL+1.
REQ-025 start while busy or in DONE SHALL be ignored; no queuing.
REQ-026 Changes on gray mid-sweep SHALL have no effect.
REQ-027 index SHALL be N+1 bits or wider so it does not wrap before the 2^N-1 compare.
REQ-028 ones SHALL never exceed 2^N (no overflow at an all-ones table).
REQ-029 Both orders SHALL visit every code 0..2^N-1 exactly once; table content SHALL be independent of order for a combinational f_in.

Reset
REQ-030 rst = 1 SHALL force the next state to IDLE, overriding start and any state including mid-sweep.
REQ-031 Reset values: vars = 0, vars_n = all ones, busy = 0, done = 0, table = 0, ones = 0, index = 0, dwell counter = 0, latched gray = 0.
REQ-032 A sweep aborted by reset SHALL NOT produce done; the next start SHALL run a complete sweep.

Verification
REQ-033 N=4, DWELL=1, gray=0, f_in = vars[3], pulse start -> vars steps 0..15 one per cycle; done in cycle 17; table = 16'hFF00; ones = 8.
REQ-034 N=4, DWELL=1, gray=1, f_in = vars[0] -> vars sequence 0,1,3,2,6,7,5,4,12,...,8; table = 16'hAAAA; ones = 8.
REQ-035 N=4, DWELL=3, f_in = (vars[3]&vars[2]) | (vars[1]&~vars[0]) -> each vars held 3 cycles; done in cycle 49; table = 16'hF444; ones = 7.
REQ-036 f_in tied to 1, N=4 -> table = 16'hFFFF, ones = 16 (no overflow); vars_n == ~vars in every cycle.
REQ-037 Assert rst at cycle 7 of a sweep -> next cycle IDLE with all outputs at reset values and no done; a new start then completes normally.
REQ-038 Pulse start at cycles 3 and 10 of a running sweep -> ignored; exactly one done; gray toggled mid-sweep -> order unchanged.
